// File: rtl/xunit_f.sv
// xunit_f: SHA-256 compression unit that consumes one schedule word per cycle
module xunit_f #(
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              done,
    input  logic [DATA_W-1:0] in0,
    input  logic [7:0]        delay0,
    input  logic              init,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [DATA_W-1:0] out4,
    output logic [DATA_W-1:0] out5,
    output logic [DATA_W-1:0] out6,
    output logic [DATA_W-1:0] out7
);
    // The round logic is written for 32-bit words and an 8-bit delay counter
    if (DATA_W != 32 || DELAY_W < 8) begin : g_bad_params
        $error("xunit_f supports DATA_W=32 and DELAY_W>=8 only");
    end

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [31:0] r_h [8];
    logic [31:0] r_v [8];
    logic [6:0]  r_round;
    logic [7:0]  r_delay;
    logic        r_busy;
    logic [31:0] w_s0, w_s1, w_ch, w_maj, w_t1, w_t2;

    // One SHA-256 round on the working registers a..h (r_v[0..7])
    always_comb begin
        w_s0  = rotr(r_v[0], 2) ^ rotr(r_v[0], 13) ^ rotr(r_v[0], 22);
        w_s1  = rotr(r_v[4], 6) ^ rotr(r_v[4], 11) ^ rotr(r_v[4], 25);
        w_ch  = (r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6]);
        w_maj = (r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]);
        w_t1  = r_v[7] + w_s1 + w_ch + K[r_round[5:0]] + in0;
        w_t2  = w_s0 + w_maj;
    end

    // Control and datapath: run wins over wait/round/final, so a run while busy aborts the block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_h[i] <= IV[i];
                r_v[i] <= '0;
            end
            r_round <= '0;
            r_delay <= '0;
            r_busy  <= 1'b0;
        end else if (run) begin
            for (int i = 0; i < 8; i++) begin
                r_h[i] <= init ? IV[i] : r_h[i];
                r_v[i] <= init ? IV[i] : r_h[i];
            end
            r_round <= '0;
            r_delay <= delay0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            if (r_delay != 8'd0) begin
                r_delay <= r_delay - 8'd1;
            end else if (!r_round[6]) begin
                r_v[0]  <= w_t1 + w_t2;
                r_v[1]  <= r_v[0];
                r_v[2]  <= r_v[1];
                r_v[3]  <= r_v[2];
                r_v[4]  <= r_v[3] + w_t1;
                r_v[5]  <= r_v[4];
                r_v[6]  <= r_v[5];
                r_v[7]  <= r_v[6];
                r_round <= r_round + 7'd1;
            end else begin
                for (int i = 0; i < 8; i++) r_h[i] <= r_h[i] + r_v[i];
                r_busy <= 1'b0;
            end
        end
    end

    assign done = !r_busy;
    assign out0 = r_h[0];
    assign out1 = r_h[1];
    assign out2 = r_h[2];
    assign out3 = r_h[3];
    assign out4 = r_h[4];
    assign out5 = r_h[5];
    assign out6 = r_h[6];
    assign out7 = r_h[7];
endmodule

// File: tb/tb_xunit_f.sv
// tb_xunit_f: directed SHA-256 vectors against xunit_f with known digests
module tb_xunit_f;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        init = 1'b0;
    logic [7:0]  delay0 = 8'd0;
    logic [31:0] in0 = 32'd0;
    logic        done;
    logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [31:0] w [64];
    int          cyc;
    int          pass_cnt = 0;
    int          tot_cnt = 0;

    localparam logic [255:0] IV_H    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_H   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_H = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] CHAIN_H = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] ABC_B   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_B = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK1_B  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK2_B  = {480'h0, 32'h000001c0};

    wire [255:0] hv = {out0, out1, out2, out3, out4, out5, out6, out7};

    xunit_f dut (
        .clk(clk), .rst_n(rst_n), .run(run), .done(done), .in0(in0), .delay0(delay0), .init(init),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out5(out5), .out6(out6), .out7(out7)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Build the 64-word message schedule from a 512-bit padded block
    task automatic load(input logic [511:0] b);
        for (int i = 0; i < 16; i++) w[i] = b[511 - 32 * i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    endtask

    task automatic start(input logic ini, input logic [7:0] d);
        @(negedge clk);
        run = 1'b1; init = ini; delay0 = d; in0 = 32'hdeadbeef;
        @(posedge clk);
        #1 run = 1'b0; init = 1'b0; delay0 = 8'hff; cyc = 0;
    endtask

    task automatic feed(input int d, input int n);
        repeat (d) begin
            @(posedge clk);
            #1 cyc++;
        end
        for (int t = 0; t < n; t++) begin
            in0 = w[t];
            @(posedge clk);
            #1 cyc++;
        end
        in0 = 32'hcafef00d;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && cyc < 300) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk);
        #1;
        tot_cnt++; if (done !== 1'b1) $display("FAIL reset_done: got %b want 1", done); else pass_cnt++;
        tot_cnt++; if (hv !== IV_H) $display("FAIL reset_h: got %h want %h", hv, IV_H); else pass_cnt++;
    endtask

    task automatic test_abc();
        load(ABC_B);
        start(1'b1, 8'd0);
        feed(0, 64);
        tot_cnt++; if (done !== 1'b0) $display("FAIL abc_busy_before_final: got %b want 0", done); else pass_cnt++;
        wait_done();
        tot_cnt++; if (cyc !== 65) $display("FAIL abc_latency: got %0d want 65", cyc); else pass_cnt++;
        tot_cnt++; if (hv !== ABC_H) $display("FAIL abc_h: got %h want %h", hv, ABC_H); else pass_cnt++;
    endtask

    task automatic test_hold();
        repeat (6) begin
            @(negedge clk) in0 = $urandom;
        end
        @(posedge clk);
        #1;
        tot_cnt++; if (hv !== ABC_H || done !== 1'b1) $display("FAIL idle_hold: got %h done=%b want %h done=1", hv, done, ABC_H); else pass_cnt++;
    endtask

    task automatic test_empty();
        load(EMPTY_B);
        start(1'b1, 8'd5);
        feed(5, 64);
        wait_done();
        tot_cnt++; if (cyc !== 70) $display("FAIL empty_latency: got %0d want 70", cyc); else pass_cnt++;
        tot_cnt++; if (hv !== EMPTY_H) $display("FAIL empty_h: got %h want %h", hv, EMPTY_H); else pass_cnt++;
    endtask

    task automatic test_chain();
        load(BLK1_B);
        start(1'b1, 8'd0);
        feed(0, 64);
        wait_done();
        tot_cnt++; if (cyc !== 65) $display("FAIL chain1_latency: got %0d want 65", cyc); else pass_cnt++;
        load(BLK2_B);
        start(1'b0, 8'd3);
        feed(3, 64);
        wait_done();
        tot_cnt++; if (cyc !== 68) $display("FAIL chain2_latency: got %0d want 68", cyc); else pass_cnt++;
        tot_cnt++; if (hv !== CHAIN_H) $display("FAIL chain_h: got %h want %h", hv, CHAIN_H); else pass_cnt++;
    endtask

    task automatic test_abort();
        do_reset();
        load(ABC_B);
        start(1'b0, 8'd0);
        feed(0, 30);
        start(1'b1, 8'd0);
        tot_cnt++; if (done !== 1'b0 || hv !== IV_H) $display("FAIL abort_restart: got done=%b h=%h want done=0 h=%h", done, hv, IV_H); else pass_cnt++;
        feed(0, 64);
        wait_done();
        tot_cnt++; if (cyc !== 65) $display("FAIL abort_latency: got %0d want 65", cyc); else pass_cnt++;
        tot_cnt++; if (hv !== ABC_H) $display("FAIL abort_h: got %h want %h", hv, ABC_H); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        load(ABC_B);
        start(1'b1, 8'd0);
        feed(0, 40);
        rst_n = 1'b0;
        #1;
        tot_cnt++; if (done !== 1'b1) $display("FAIL midreset_done: got %b want 1", done); else pass_cnt++;
        tot_cnt++; if (hv !== IV_H) $display("FAIL midreset_h: got %h want %h", hv, IV_H); else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tot_cnt++; if (done !== 1'b1) $display("FAIL midreset_idle: got %b want 1", done); else pass_cnt++;
        start(1'b1, 8'd0);
        feed(0, 64);
        wait_done();
        tot_cnt++; if (hv !== ABC_H) $display("FAIL midreset_abc_h: got %h want %h", hv, ABC_H); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_abc();
        test_hold();
        test_empty();
        test_chain();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/xunit_f.md
XUNIT_F -- requirements
Module: xunit_f

Interface
REQ-001 Parameter DATA_W, default 32, datapath word width; only 32 is supported.
REQ-002 Parameter DELAY_W, default 10, reserved delay width; the delay0 port is fixed at 8 bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  start pulse; samples the configuration inputs and begins one 512-bit block.
REQ-006 done  output  1  high when idle; low while a block is in progress.
REQ-007 in0  input  32  schedule word W_t stream, one word per active cycle, t=0..63.
REQ-008 delay0  input  8  configuration: cycles to wait after run before W_0 is valid on in0.
REQ-009 init  input  1  configuration: when 1 at run, the hash state H is reloaded with the SHA-256 IV before compression.
REQ-010 out0..out7  output  32 each  hash state H0..H7, registered.

Function
REQ-011 State SHALL be: H0..H7, working registers a..h, round counter (7 bits, 0..64), delay counter (8 bits), and busy flag; done SHALL equal !busy.
REQ-012 On run: delay<=delay0, round<=0, busy<=1, a..h<=H; if init=1, H<=IV and a..h<=IV in the same cycle.
REQ-013 IV SHALL be 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
REQ-014 WAIT: while busy and delay!=0, delay SHALL decrement by 1 per cycle; no other state changes and in0 is ignored.
REQ-015 ROUND: while busy, delay==0 and round<64, the unit SHALL apply one SHA-256 round per cycle using W=in0 and K[round], then increment round.
REQ-016 Round equations: T1=h+S1(e)+Ch(e,f,g)+K+W; T2=S0(a)+Maj(a,b,c); h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
REQ-017 S0=ROTR2^ROTR13^ROTR22; S1=ROTR6^ROTR11^ROTR25; Ch=(e&f)^(~e&g); Maj=(a&b)^(a&c)^(b&c).
REQ-018 All additions SHALL be modulo 2^32 with no carry out.
REQ-019 K[0..63] SHALL be the standard SHA-256 round-constant table, held in an internal combinational ROM indexed by round[5:0].
REQ-020 FINAL: while busy, delay==0 and round==64: Hi<=Hi+{a..h}[i] for all i, busy<=0.
REQ-021 Latency: done SHALL return high exactly delay0+65 cycles after the run cycle, and out0..out7 SHALL hold the new H on that same cycle.
REQ-022 When idle, H SHALL hold; with init=0, consecutive runs SHALL chain blocks.
REQ-023 A run while busy SHALL abort the block: the REQ-012 actions are taken, and H is unchanged by the aborted block.
REQ-024 run SHALL take priority over WAIT, ROUND and FINAL in the same cycle.
REQ-025 delay0=0: the first ROUND SHALL occur in the cycle after run.

Reset
REQ-026 While rst_n=0: H<=IV, a..h<=0, round<=0, delay<=0, busy<=0; therefore done=1 and out0..out7=IV.
REQ-027 rst_n asserted mid-block SHALL discard the block immediately; after release the unit SHALL be idle and wait for run.

Verification
REQ-028 Reset: drive rst_n low then high -> done=1, out0=6a09e667 ... out7=5be0cd19.
REQ-029 "abc": run with init=1, delay0=0, feed the 64 schedule words of padded block (W0=61626380, W15=00000018) -> after 65 cycles, H = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-030 Empty message: init=1, delay0=5, W0=80000000, all other input words 0 before expansion -> done rises 70 cycles after run; H = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-031 Two-block chaining: "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", block 1 run with init=1, block 2 run with init=0 -> H = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-032 Abort: start "abc" with init=0 from IV, re-pulse run (init=1) at round 30, then feed the full "abc" stream -> final H equals the REQ-029 digest.
REQ-033 Reset mid-block: assert rst_n=0 at round 40 -> done=1 and out=IV immediately; a subsequent "abc" run yields the REQ-029 digest.
